// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage core, with an EX-stall watchdog.
// Optional: define STALL_PERF_CNT_EN to add a saturating stalled-cycle counter (stall_cnt_o).
module pipe_stall_ctrl #(
  parameter int EX_TIMEOUT = 64
`ifdef STALL_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id_i,
  input  logic       stallreq_ex_i,
  input  logic       flush_req_i,
  output logic [5:0] stall_o,
  output logic       flush_o,
  output logic       timeout_o,
  output logic [1:0] state_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int CW = $clog2(EX_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ID_HOLD = 2'd1,
    EX_HOLD = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ex_cnt, ex_cnt_nxt;
  logic          wd_fire;

  // ex_cnt includes the cycle that first raised the EX stall, so EX_TIMEOUT-1 stalled cycles precede release.
  always_comb begin
    state_nxt  = state;
    ex_cnt_nxt = '0;
    stall_o    = 6'b000000;
    wd_fire    = (state == EX_HOLD) && stallreq_ex_i && !flush_req_i &&
                 (ex_cnt == CW'(EX_TIMEOUT - 1));

    if (rst && !flush_req_i && (state != FLUSH) && !wd_fire) begin
      if (stallreq_ex_i)
        stall_o = 6'b001111;
      else if (stallreq_id_i)
        stall_o = 6'b000111;
    end

    if (flush_req_i)
      state_nxt = FLUSH;
    else if (wd_fire)
      state_nxt = RUN;
    else begin
      case (state)
        RUN, ID_HOLD, EX_HOLD: begin
          if (stallreq_ex_i)
            state_nxt = EX_HOLD;
          else if (stallreq_id_i)
            state_nxt = ID_HOLD;
          else
            state_nxt = RUN;
        end
        FLUSH:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end

    if (state_nxt == EX_HOLD)
      ex_cnt_nxt = (state == EX_HOLD) ? ex_cnt + CW'(1) : CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      ex_cnt    <= '0;
      flush_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      ex_cnt    <= ex_cnt_nxt;
      flush_o   <= (state_nxt == FLUSH);
      timeout_o <= timeout_o | wd_fire;
    end
  end

  assign state_o = state;

`ifdef STALL_PERF_CNT_EN
  // Saturates rather than wrapping so a long-running core never reports a small count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_o <= '0;
    else if ((stall_o != 6'b000000) && (stall_cnt_o != {CNT_W{1'b1}}))
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random traffic
// against a history-based reference model (EX_TIMEOUT=4, CNT_W=4 when STALL_PERF_CNT_EN).
module tb_pipe_stall_ctrl;

  localparam int T     = 4;
  localparam int TCW   = 4;
  localparam int CMAX  = (1 << TCW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stallreq_id_i = 1'b0;
  logic       stallreq_ex_i = 1'b0;
  logic       flush_req_i = 1'b0;
  logic [5:0] stall_o;
  logic       flush_o;
  logic       timeout_o;
  logic [1:0] state_o;
`ifdef STALL_PERF_CNT_EN
  logic [TCW-1:0] stall_cnt_o;
`endif

  pipe_stall_ctrl #(
    .EX_TIMEOUT(T)
`ifdef STALL_PERF_CNT_EN
    ,
    .CNT_W(TCW)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i),
    .flush_req_i(flush_req_i),
    .stall_o(stall_o),
    .flush_o(flush_o),
    .timeout_o(timeout_o),
    .state_o(state_o)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model history: what the previous cycle requested and produced.
  bit h_flush, h_inflush, h_release, h_ex, h_id;
  int h_streak;
  bit m_timeout;
  int m_perf;
  bit pending;
  bit cur_id, cur_ex, cur_fl, cur_inflush, cur_release;

  logic [5:0] exp_stall;
  logic [1:0] exp_state;
  logic       exp_flush;
  logic       exp_timeout;
  int         exp_cnt;

  task automatic model_clear();
    h_flush = 0; h_inflush = 0; h_release = 0; h_ex = 0; h_id = 0;
    h_streak = 0; m_timeout = 0; m_perf = 0; pending = 0;
  endtask

  task automatic model_commit();
    h_inflush = cur_inflush;
    h_flush   = cur_fl;
    h_release = cur_release;
    h_ex      = cur_ex;
    h_id      = cur_id;
    h_streak  = (exp_stall == 6'b001111) ? h_streak + 1 : 0;
    if (cur_release) m_timeout = 1;
    if (exp_stall != 6'b000000 && m_perf < CMAX) m_perf = m_perf + 1;
  endtask

  // Drive one cycle of requests (mid-low-phase) and predict the outputs for it.
  task automatic apply_stimulus(input bit id, input bit ex, input bit fl);
    @(negedge clk);
    if (pending) model_commit();
    stallreq_id_i = id; stallreq_ex_i = ex; flush_req_i = fl;
    cur_id = id; cur_ex = ex; cur_fl = fl;
    cur_inflush = h_flush;
    if (h_flush)         exp_state = 2'd3;
    else if (h_inflush)  exp_state = 2'd0;
    else if (h_release)  exp_state = 2'd0;
    else if (h_ex)       exp_state = 2'd2;
    else if (h_id)       exp_state = 2'd1;
    else                 exp_state = 2'd0;
    cur_release = !fl && !cur_inflush && ex && (h_streak == T - 1);
    if (fl || cur_inflush || cur_release) exp_stall = 6'b000000;
    else if (ex)                          exp_stall = 6'b001111;
    else if (id)                          exp_stall = 6'b000111;
    else                                  exp_stall = 6'b000000;
    exp_flush   = cur_inflush;
    exp_timeout = m_timeout;
    exp_cnt     = m_perf;
    pending = 1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stallreq_id_i = 0; stallreq_ex_i = 0; flush_req_i = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stallreq_ex_i = 1'b1;
    #3;
    repeat (2) begin
      @(negedge clk); #1;
      n_vec++;
      if (stall_o !== 6'b000000 || state_o !== 2'd0 || flush_o !== 1'b0 || timeout_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs: got stall=%b state=%0d flush=%b timeout=%b want 000000/0/0/0",
                 stall_o, state_o, flush_o, timeout_o);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (stall_o !== 6'b001111 || state_o !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got stall=%b state=%0d want 001111/0", stall_o, state_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if (state_o !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL reset_to_ex_hold: got state=%0d want 2", state_o);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(i < 2, 0, 0);
      n_vec++;
      if (stall_o !== ((i < 2) ? 6'b000111 : 6'b000000) || stall_o !== exp_stall) begin
        n_fail++;
        $display("[TB] FAIL load_use_stall cyc %0d: got %b want %b", i, stall_o, exp_stall);
      end
      n_vec++;
      if (state_o !== exp_state) begin
        n_fail++;
        $display("[TB] FAIL load_use_state cyc %0d: got %0d want %0d", i, state_o, exp_state);
      end
    end
  endtask

  task automatic test_overlap();
    logic [5:0] want [5];
    want[0] = 6'b000111; want[1] = 6'b001111; want[2] = 6'b001111;
    want[3] = 6'b000111; want[4] = 6'b000111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, (i == 1) || (i == 2), 0);
      n_vec++;
      if (stall_o !== want[i] || stall_o !== exp_stall) begin
        n_fail++;
        $display("[TB] FAIL overlap_stall cyc %0d: got %b want %b", i, stall_o, want[i]);
      end
      n_vec++;
      if (state_o !== exp_state) begin
        n_fail++;
        $display("[TB] FAIL overlap_state cyc %0d: got %0d want %0d", i, state_o, exp_state);
      end
    end
  endtask

  task automatic test_flush_vs_stall();
    do_reset();
    apply_stimulus(0, 1, 1);
    n_vec++;
    if (stall_o !== 6'b000000) begin
      n_fail++;
      $display("[TB] FAIL flush_stall_gate: got %b want 000000", stall_o);
    end
    apply_stimulus(0, 0, 0);
    n_vec++;
    if (flush_o !== 1'b1 || state_o !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL flush_pulse: got flush=%b state=%0d want 1/3", flush_o, state_o);
    end
    apply_stimulus(0, 0, 0);
    n_vec++;
    if (flush_o !== 1'b0 || state_o !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL flush_return: got flush=%b state=%0d want 0/0", flush_o, state_o);
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 1, 1);
      n_vec++;
      if (flush_o !== exp_flush || stall_o !== 6'b000000 || state_o !== exp_state) begin
        n_fail++;
        $display("[TB] FAIL flush_held cyc %0d: got flush=%b stall=%b state=%0d want %b/000000/%0d",
                 i, flush_o, stall_o, state_o, exp_flush, exp_state);
      end
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 1, 0);
      n_vec++;
      if (stall_o !== exp_stall || (i < 4 && stall_o !== ((i == 3) ? 6'b000000 : 6'b001111))) begin
        n_fail++;
        $display("[TB] FAIL wd_stall cyc %0d: got %b want %b", i, stall_o, exp_stall);
      end
      n_vec++;
      if (timeout_o !== exp_timeout || (i >= 4 && timeout_o !== 1'b1)) begin
        n_fail++;
        $display("[TB] FAIL wd_timeout cyc %0d: got %b want %b", i, timeout_o, exp_timeout);
      end
      n_vec++;
      if (state_o !== exp_state) begin
        n_fail++;
        $display("[TB] FAIL wd_state cyc %0d: got %0d want %0d", i, state_o, exp_state);
      end
    end
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0);
    n_vec++;
    if (timeout_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wd_sticky: got %b want 1", timeout_o);
    end
  endtask

  task automatic test_async_reset_midstall();
    do_reset();
    apply_stimulus(0, 1, 0);
    apply_stimulus(0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (stall_o !== 6'b000000 || state_o !== 2'd0 || flush_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got stall=%b state=%0d flush=%b want 000000/0/0",
               stall_o, state_o, flush_o);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit id, ex, fl;
    do_reset();
    ex = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) ex = ~ex;
      id = ($urandom_range(2) != 0);
      fl = ($urandom_range(14) == 0);
      apply_stimulus(id, ex, fl);
      n_vec++;
      if (stall_o !== exp_stall || state_o !== exp_state || flush_o !== exp_flush ||
          timeout_o !== exp_timeout) begin
        n_fail++;
        $display("[TB] FAIL random cyc %0d: got stall=%b state=%0d flush=%b to=%b want %b/%0d/%b/%b",
                 i, stall_o, state_o, flush_o, timeout_o, exp_stall, exp_state, exp_flush, exp_timeout);
      end
`ifdef STALL_PERF_CNT_EN
      n_vec++;
      if (stall_cnt_o !== TCW'(exp_cnt)) begin
        n_fail++;
        $display("[TB] FAIL random_cnt cyc %0d: got %0d want %0d", i, stall_cnt_o, exp_cnt);
      end
`endif
    end
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 1, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(1, 1, 0);
    apply_stimulus(1, 0, 0);
    apply_stimulus(0, 1, 0);
    apply_stimulus(0, 0, 0);
    n_vec++;
    if (stall_cnt_o !== TCW'(5) || stall_cnt_o !== TCW'(exp_cnt)) begin
      n_fail++;
      $display("[TB] FAIL perf_count: got %0d want 5", stall_cnt_o);
    end
    for (int i = 0; i < 20; i++) apply_stimulus(1, 0, 0);
    apply_stimulus(0, 0, 0);
    n_vec++;
    if (stall_cnt_o !== TCW'(CMAX)) begin
      n_fail++;
      $display("[TB] FAIL perf_saturate: got %0d want %0d", stall_cnt_o, CMAX);
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_load_use();
    test_overlap();
    test_flush_vs_stall();
    test_watchdog();
    test_async_reset_midstall();
    test_random();
`ifdef STALL_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
